// File: rtl/timer_pkg.sv
// Shared types for the programmable timer/counter: counting modes and FSM states.
package timer_pkg;

  typedef enum logic [1:0] {
    TMR_FREE     = 2'd0,
    TMR_PERIODIC = 2'd1,
    TMR_ONESHOT  = 2'd2,
    TMR_DOWN     = 2'd3
  } tmr_mode_e;

  typedef enum logic [1:0] {
    TMR_IDLE    = 2'd0,
    TMR_RUN     = 2'd1,
    TMR_EXPIRED = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/timer_prescaler.sv
// Divide-by-PRESCALE tick generator for the timer; counts 0..PRESCALE-1 while run is high.
module timer_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic newclk_k,
  input  logic rstn,
  input  logic run,
  input  logic restart,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt;

  assign tick = run && (cnt == LAST);

  always_ff @(posedge newclk_k or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/timer_counter_n.sv
// Programmable WIDTH-bit timer/counter (free-run, periodic, one-shot, down/auto-reload).
// Define TIMER_PRESCALE_EN to gate count advances with a divide-by-PRESCALE prescaler.
module timer_counter_n
  import timer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             newclk_k,
  input  logic             rstn,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] out,
  output logic             trig,
  output logic             busy,
  output logic             done
);

  if (WIDTH < 2) begin : g_bad_width
    $error("timer_counter_n: WIDTH must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("timer_counter_n: PRESCALE must be >= 1");
  end

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  tmr_state_e       state;
  tmr_mode_e        mode_q;
  logic             tick;
  logic             advance;
  logic [WIDTH-1:0] nxt_val;
  logic             nxt_match;

`ifdef TIMER_PRESCALE_EN
  timer_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .newclk_k (newclk_k),
    .rstn     (rstn),
    .run      ((state == TMR_RUN) && en),
    .restart  (clr || load || ((state == TMR_IDLE) && en)),
    .tick     (tick)
  );
`else
  assign tick = 1'b1;
`endif

  // en low at an edge both leaves RUN and suppresses that edge's advance.
  assign advance = (state == TMR_RUN) && en && tick;
  assign busy    = (state == TMR_RUN);

  always_comb begin
    nxt_val = out + ONE;
    unique case (mode_q)
      TMR_FREE, TMR_ONESHOT: nxt_val = out + ONE;
      TMR_PERIODIC:          nxt_val = (out == cmp_val) ? '0 : out + ONE;
      TMR_DOWN:              nxt_val = (out == '0) ? load_val : out - ONE;
      default:               nxt_val = out + ONE;
    endcase
    nxt_match = (mode_q == TMR_DOWN) ? (nxt_val == '0) : (nxt_val == cmp_val);
  end

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge newclk_k or negedge rstn) begin
    if (!rstn) begin
      state  <= TMR_IDLE;
      mode_q <= TMR_FREE;
      out    <= '0;
      trig   <= 1'b0;
      done   <= 1'b0;
    end else begin
      trig <= 1'b0;

      unique case (state)
        TMR_IDLE: begin
          if (en) begin
            state  <= TMR_RUN;
            mode_q <= tmr_mode_e'(mode);
          end
        end
        TMR_RUN:     if (!en) state <= TMR_IDLE;
        TMR_EXPIRED: if (clr || load) state <= TMR_IDLE;
        default:     state <= TMR_IDLE;
      endcase

      if (clr) begin
        out  <= '0;
        done <= 1'b0;
      end else if (load) begin
        out  <= load_val;
        done <= 1'b0;
      end else if (advance) begin
        out  <= nxt_val;
        trig <= nxt_match;
        if ((mode_q == TMR_ONESHOT) && nxt_match) begin
          state <= TMR_EXPIRED;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timer_counter_n.sv
// Directed self-checking bench for timer_counter_n (default build, WIDTH=8).
module tb_timer_counter_n;

  localparam int WIDTH = 8;

  logic             newclk_k;
  logic             rstn;
  logic             en;
  logic [1:0]       mode;
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] cmp_val;
  logic [WIDTH-1:0] out;
  logic             trig;
  logic             busy;
  logic             done;

  int n_tests = 0;
  int n_fail  = 0;

  timer_counter_n #(
    .WIDTH    (WIDTH),
    .PRESCALE (4)
  ) dut (
    .newclk_k (newclk_k),
    .rstn     (rstn),
    .en       (en),
    .mode     (mode),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .cmp_val  (cmp_val),
    .out      (out),
    .trig     (trig),
    .busy     (busy),
    .done     (done)
  );

  initial newclk_k = 1'b0;
  always #5 newclk_k = ~newclk_k;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs and samples both land 1 time unit after it.
  task automatic step();
    @(posedge newclk_k);
    #1;
  endtask

  task automatic expect_ot(input string tag, input int o, input bit t);
    step();
    check({tag, ".out"}, 32'(out), 32'(o));
    check({tag, ".trig"}, 32'(trig), 32'(t));
  endtask

  // Stop, clear and return to IDLE.
  task automatic park();
    en  = 1'b0;
    clr = 1'b1;
    step();
    clr = 1'b0;
    step();
  endtask

  initial begin
    int per_seq[10];
    int dn_seq[7];

    rstn = 1'b0; en = 1'b0; mode = 2'd0; clr = 1'b0; load = 1'b0;
    load_val = '0; cmp_val = '0;
    #12;
    check("rst.out",  32'(out),  32'd0);
    check("rst.trig", 32'(trig), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    step();
    rstn = 1'b1;

    // FREE, cmp=3
    mode = 2'd0; cmp_val = 8'd3; en = 1'b1;
    step();
    check("free.busy", 32'(busy), 32'd1);
    check("free.out0", 32'(out), 32'd0);
    for (int v = 1; v <= 255; v++) expect_ot("free", v, v == 3);
    for (int v = 0; v <= 4; v++)   expect_ot("free_wrap", v, v == 3);
    en = 1'b0;
    step();
    check("free.stop_busy", 32'(busy), 32'd0);
    check("free.stop_out",  32'(out),  32'd4);
    step();
    check("free.hold_out",  32'(out),  32'd4);

    // PERIODIC, cmp=4
    park();
    mode = 2'd1; cmp_val = 8'd4; en = 1'b1;
    step();
    per_seq = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0};
    foreach (per_seq[i]) expect_ot("per4", per_seq[i], per_seq[i] == 4);
    park();
    cmp_val = 8'd0; en = 1'b1;
    step();
    for (int i = 0; i < 4; i++) expect_ot("per0", 0, 1'b1);

    // ONESHOT, cmp=6
    park();
    mode = 2'd2; cmp_val = 8'd6; en = 1'b1;
    step();
    for (int v = 1; v <= 5; v++) expect_ot("one", v, 1'b0);
    expect_ot("one.hit", 6, 1'b1);
    check("one.done", 32'(done), 32'd1);
    check("one.busy", 32'(busy), 32'd0);
    en = 1'b0;
    expect_ot("one.en0", 6, 1'b0);
    en = 1'b1;
    expect_ot("one.en1", 6, 1'b0);
    check("one.done_hold", 32'(done), 32'd1);
    check("one.busy_hold", 32'(busy), 32'd0);
    en = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("one.clr_out",  32'(out),  32'd0);
    check("one.clr_done", 32'(done), 32'd0);
    step();
    check("one.idle_busy", 32'(busy), 32'd0);
    check("one.idle_out",  32'(out),  32'd0);

    // DOWN with load 5
    mode = 2'd3; load_val = 8'd5; load = 1'b1;
    step();
    load = 1'b0;
    check("dn.load", 32'(out), 32'd5);
    en = 1'b1;
    step();
    check("dn.busy", 32'(busy), 32'd1);
    dn_seq = '{4, 3, 2, 1, 0, 5, 4};
    foreach (dn_seq[i]) expect_ot("dn", dn_seq[i], dn_seq[i] == 0);
    clr = 1'b1; load = 1'b1;
    step();
    clr = 1'b0; load = 1'b0;
    check("dn.clr_ld_out",  32'(out),  32'd0);
    check("dn.clr_ld_trig", 32'(trig), 32'd0);
    expect_ot("dn.reload", 5, 1'b0);

    // Mid-run async reset at 0x37
    park();
    mode = 2'd0; cmp_val = 8'hF0; load_val = 8'h35; load = 1'b1;
    step();
    load = 1'b0; en = 1'b1;
    step();
    expect_ot("mid", 8'h36, 1'b0);
    expect_ot("mid", 8'h37, 1'b0);
    rstn = 1'b0;
    #1;
    check("mid.rst_out",  32'(out),  32'd0);
    check("mid.rst_busy", 32'(busy), 32'd0);
    en = 1'b0;
    step();
    rstn = 1'b1;

    // Mode change during RUN ignored until next IDLE->RUN
    mode = 2'd0; cmp_val = 8'h80; en = 1'b1;
    step();
    expect_ot("mchg.free", 1, 1'b0);
    mode = 2'd3;
    expect_ot("mchg.ignored", 2, 1'b0);
    en = 1'b0;
    expect_ot("mchg.stop", 2, 1'b0);
    en = 1'b1;
    expect_ot("mchg.start", 2, 1'b0);
    expect_ot("mchg.down", 1, 1'b0);
    expect_ot("mchg.down0", 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
